washing_machine_ctrl: RTL and testbench

- Top-level control FSM for a washing machine appliance.
- Sequences one complete programme: door check/lock, fill, detergent, soap wash, drain, rinse (fill, wash, drain), spin, done.
- Drives valve, motor and lock actuators and reports phase-completion flags.
- Sensor and timer inputs come from external plant and timer blocks as level signals.

---
 rtl/washing_machine_ctrl.sv | 118 +++++++++++
 tb/tb_washing_machine_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/washing_machine_ctrl.sv
// Washing machine programme sequencer: door lock, fill, detergent, wash, drain, rinse, spin, done.
// Optional WM_STATE_OUT_EN adds a state_dbg port that mirrors the state register.
module washing_machine_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       door_close,
    input  logic       start,
    input  logic       water_filled,
    input  logic       add_detergent,
    input  logic       cycle_timeout,
    input  logic       water_drained,
    input  logic       spin_timeout,
    output logic       door_lock,
    output logic       motor_on,
    output logic       fill_value_on,
    output logic       drain_value_on,
    output logic       done,
    output logic       soap_wash,
    output logic       water_wash
`ifdef WM_STATE_OUT_EN
    ,
    output logic [2:0] state_dbg
`endif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        DETERGENT = 3'd2,
        WASH      = 3'd3,
        DRAIN     = 3'd4,
        SPIN      = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   soap_nxt;
    logic   water_nxt;

    always_comb begin
        state_nxt = state;
        soap_nxt  = soap_wash;
        water_nxt = water_wash;
        case (state)
            IDLE: begin
                soap_nxt  = 1'b0;
                water_nxt = 1'b0;
                if (start && door_close) state_nxt = FILL;
            end
            FILL: begin
                if (water_filled) state_nxt = soap_wash ? WASH : DETERGENT;
            end
            DETERGENT: begin
                if (add_detergent) begin
                    state_nxt = WASH;
                    soap_nxt  = 1'b1;
                end
            end
            WASH: begin
                if (cycle_timeout) state_nxt = DRAIN;
            end
            DRAIN: begin
                // The first drain ends the soap wash and starts the rinse pass.
                if (water_drained) begin
                    if (water_wash) begin
                        state_nxt = SPIN;
                    end else begin
                        state_nxt = FILL;
                        water_nxt = 1'b1;
                    end
                end
            end
            SPIN: begin
                if (spin_timeout) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                soap_nxt  = 1'b0;
                water_nxt = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                soap_nxt  = 1'b0;
                water_nxt = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered values track the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            soap_wash      <= 1'b0;
            water_wash     <= 1'b0;
            door_lock      <= 1'b0;
            motor_on       <= 1'b0;
            fill_value_on  <= 1'b0;
            drain_value_on <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_nxt;
            soap_wash      <= soap_nxt;
            water_wash     <= water_nxt;
            door_lock      <= (state_nxt == FILL) || (state_nxt == DETERGENT) || (state_nxt == WASH) ||
                              (state_nxt == DRAIN) || (state_nxt == SPIN);
            motor_on       <= (state_nxt == WASH) || (state_nxt == SPIN);
            fill_value_on  <= (state_nxt == FILL);
            drain_value_on <= (state_nxt == DRAIN) || (state_nxt == SPIN);
            done           <= (state_nxt == DONE);
        end
    end

`ifdef WM_STATE_OUT_EN
    assign state_dbg = state;
`endif

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// Bench for washing_machine_ctrl: vector table, directed corner sequences and random stimulus
// against a programme-step model.
module tb_washing_machine_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, door_close, start, water_filled, add_detergent;
    logic cycle_timeout, water_drained, spin_timeout;
    logic door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash;
`ifdef WM_STATE_OUT_EN
    logic [2:0] state_dbg;
`endif

    washing_machine_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .door_close     (door_close),
        .start          (start),
        .water_filled   (water_filled),
        .add_detergent  (add_detergent),
        .cycle_timeout  (cycle_timeout),
        .water_drained  (water_drained),
        .spin_timeout   (spin_timeout),
        .door_lock      (door_lock),
        .motor_on       (motor_on),
        .fill_value_on  (fill_value_on),
        .drain_value_on (drain_value_on),
        .done           (done),
        .soap_wash      (soap_wash),
        .water_wash     (water_wash)
`ifdef WM_STATE_OUT_EN
        ,
        .state_dbg      (state_dbg)
`endif
    );

    // Input vector: {reset, door_close, start, water_filled, add_detergent, cycle_timeout, water_drained, spin_timeout}
    // Output vector: {door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash}
    typedef struct {
        logic [7:0] in;
        logic [6:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int pos    = 0;   // programme step: 0 idle, 1..9 = FILL DET WASH DRAIN FILL WASH DRAIN SPIN DONE

    logic [6:0] dut_out;
    assign dut_out = {door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash};

    function automatic logic [6:0] model_out(int p);
        logic [6:0] o;
        o[6] = (p >= 1) && (p <= 8);
        o[5] = (p == 3) || (p == 6) || (p == 8);
        o[4] = (p == 1) || (p == 5);
        o[3] = (p == 4) || (p == 7) || (p == 8);
        o[2] = (p == 9);
        o[1] = (p >= 3);
        o[0] = (p >= 5);
        return o;
    endfunction

    function automatic int model_next(int p, logic [7:0] in);
        logic adv;
        if (!in[7]) return 0;
        if (p == 0) return (in[6] && in[5]) ? 1 : 0;
        if (p == 9) return 0;
        case (p)
            1, 5:    adv = in[4];
            2:       adv = in[3];
            3, 6:    adv = in[2];
            4, 7:    adv = in[1];
            default: adv = in[0];
        endcase
        return adv ? p + 1 : p;
    endfunction

    function automatic logic [2:0] model_state(int p);
        logic [2:0] enc [10];
        enc = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
        return enc[p];
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [7:0] in);
        @(negedge clk);
        {reset, door_close, start, water_filled, add_detergent, cycle_timeout, water_drained, spin_timeout} = in;
        @(posedge clk);
        pos = model_next(pos, in);
        #1;
        check("model", dut_out, model_out(pos));
        checks++;
        if (fill_value_on === 1'b1 && drain_value_on === 1'b1) begin
            errors++;
            $display("FAIL exclusive: fill=%b drain=%b both high (t=%0t)", fill_value_on, drain_value_on, $time);
        end
`ifdef WM_STATE_OUT_EN
        check("state_dbg", {4'b0, state_dbg}, {4'b0, model_state(pos)});
`endif
    endtask

    vec_t vecs [14];

    initial begin
        {reset, door_close, start, water_filled, add_detergent, cycle_timeout, water_drained, spin_timeout} = 8'h00;

        vecs[0]  = '{8'b0111_1111, 7'b0000000};
        vecs[1]  = '{8'b0101_0110, 7'b0000000};
        vecs[2]  = '{8'b1111_1111, 7'b1010000};
        vecs[3]  = '{8'b1111_1111, 7'b1000000};
        vecs[4]  = '{8'b1111_1111, 7'b1100010};
        vecs[5]  = '{8'b1111_1111, 7'b1001010};
        vecs[6]  = '{8'b1111_1111, 7'b1010011};
        vecs[7]  = '{8'b1111_1111, 7'b1100011};
        vecs[8]  = '{8'b1111_1111, 7'b1001011};
        vecs[9]  = '{8'b1111_1111, 7'b1101011};
        vecs[10] = '{8'b1111_1111, 7'b0000111};
        vecs[11] = '{8'b1111_1111, 7'b0000000};
        vecs[12] = '{8'b1111_1111, 7'b1010000};
        vecs[13] = '{8'b0111_1111, 7'b0000000};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].in);
            check($sformatf("vec%0d", i), dut_out, vecs[i].exp);
        end

        // Door open: start held, door never closed
        for (int i = 0; i < 10; i++) step(8'b1010_1111);
        check("door_open_idle", dut_out, 7'b0000000);
        step(8'b1110_0000);
        check("door_close_fill", dut_out, 7'b1010000);

        // Stall in FILL while door toggles; other sensors high but ignored
        for (int i = 0; i < 20; i++) step({1'b1, i[0], 1'b0, 1'b0, 4'b1111});
        check("fill_stall", dut_out, 7'b1010000);
        step(8'b1001_0000);
        check("fill_to_det", dut_out, 7'b1000000);

        // Mid-programme reset from SPIN, then full restart through DETERGENT
        step(8'b0000_0000);
        for (int i = 0; i < 8; i++) step(8'b1111_1111);
        check("reach_spin", dut_out, 7'b1101011);
        step(8'b0111_1111);
        check("spin_reset", dut_out, 7'b0000000);
        step(8'b1110_0000);
        step(8'b1001_0000);
        check("restart_det", dut_out, 7'b1000000);
        for (int i = 0; i < 7; i++) step(8'b1001_1111);
        check("restart_done", dut_out, 7'b0000111);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            r[7] = ($urandom_range(0, 31) != 0);
            step(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
